// File: rtl/sm_muldiv.sv
// rtl/sm_muldiv.sv - iterative unsigned multiply/divide unit with HI/LO result registers
module sm_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       oper,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_MULTU = 2'd0;
    localparam logic [1:0] OP_DIVU  = 2'd1;
    localparam logic [1:0] OP_MTHI  = 2'd2;
    localparam logic [1:0] OP_MTLO  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic             r_div;
    logic [WIDTH:0]   r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_divz;

    logic             w_accept;
    logic             w_iter;
    logic             w_last;

    // r_x holds the partial-product upper half or the remainder; r_y the multiplier or quotient
    logic [WIDTH:0]   w_madd;
    logic [WIDTH:0]   w_mx_n;
    logic [WIDTH-1:0] w_my_n;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH:0]   w_dx_n;
    logic [WIDTH-1:0] w_dy_n;
    logic [WIDTH:0]   w_x_n;
    logic [WIDTH-1:0] w_y_n;

    assign w_accept = start && (r_state != S_RUN);
    assign w_iter   = w_accept && ((oper == OP_MULTU) || (oper == OP_DIVU));
    assign w_last   = (r_cnt == '0);

    always_comb begin
        w_madd = r_x + (r_y[0] ? {1'b0, r_b} : '0);
        w_mx_n = {1'b0, w_madd[WIDTH:1]};
        w_my_n = {w_madd[0], r_y[WIDTH-1:1]};
    end

    // Restoring step: shift in the next dividend bit, subtract only when it fits
    always_comb begin
        w_shift = {r_x[WIDTH-1:0], r_y[WIDTH-1]};
        w_ge    = (w_shift >= {1'b0, r_b});
        w_diff  = w_shift - {1'b0, r_b};
        w_dx_n  = w_ge ? w_diff : w_shift;
        w_dy_n  = {r_y[WIDTH-2:0], w_ge};
    end

    always_comb begin
        w_x_n = r_div ? w_dx_n : w_mx_n;
        w_y_n = r_div ? w_dy_n : w_my_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_iter ? S_RUN : S_IDLE;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = w_iter ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_RUN);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_x    <= '0;
            r_y    <= '0;
            r_b    <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
            r_divz <= 1'b0;
        end else if (w_accept) begin
            case (oper)
                OP_MULTU: begin
                    r_x   <= '0;
                    r_y   <= srcB;
                    r_b   <= srcA;
                    r_cnt <= CW'(WIDTH - 1);
                    r_div <= 1'b0;
                end
                OP_DIVU: begin
                    r_x   <= '0;
                    r_y   <= srcA;
                    r_b   <= srcB;
                    r_cnt <= CW'(WIDTH - 1);
                    r_div <= 1'b1;
                end
                OP_MTHI: r_hi <= srcA;
                OP_MTLO: r_lo <= srcA;
                default: ;
            endcase
        end else if (r_state == S_RUN) begin
            r_x <= w_x_n;
            r_y <= w_y_n;
            if (w_last) begin
                r_hi   <= w_x_n[WIDTH-1:0];
                r_lo   <= w_y_n;
                r_divz <= r_div && (r_b == '0);
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign hi      = r_hi;
    assign lo      = r_lo;
    assign divZero = r_divz;

endmodule

// File: tb/tb_sm_muldiv.sv
// tb/tb_sm_muldiv.sv - scoreboard bench for sm_muldiv against an arithmetic reference model
module tb_sm_muldiv;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   oper;
    logic [W-1:0] srcA, srcB;
    logic         busy, done, divZero;
    logic [W-1:0] hi, lo;

    logic         start8;
    logic [1:0]   oper8;
    logic [7:0]   srcA8, srcB8;
    logic         busy8, done8, divZero8;
    logic [7:0]   hi8, lo8;

    exp_t         sb[$];
    logic [W-1:0] m_hi, m_lo;
    logic         m_dz;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           busy_run = 0;

    always #5 clk = ~clk;

    sm_muldiv #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .oper(oper), .srcA(srcA), .srcB(srcB),
        .busy(busy), .done(done), .divZero(divZero), .hi(hi), .lo(lo)
    );

    sm_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .oper(oper8), .srcA(srcA8), .srcB(srcB8),
        .busy(busy8), .done(done8), .divZero(divZero8), .hi(hi8), .lo(lo8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t         e;
        logic [2*W-1:0] p;
        if (op == 2'd0) begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            e = '{p[2*W-1:W], p[W-1:0], 1'b0};
        end else if (b == '0) begin
            e = '{a, {W{1'b1}}, 1'b1};
        end else begin
            e = '{a % b, a / b, 1'b0};
        end
        return e;
    endfunction

    task automatic wait_free();
        int t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("wait_free_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        wait_free();
        start = 1'b1; oper = op; srcA = a; srcB = b;
        if (op <= 2'd1) begin
            e = model(op, a, b);
            sb.push_back(e);
            m_hi = e.hi; m_lo = e.lo; m_dz = e.dz;
        end else if (op == 2'd2) begin
            m_hi = a;
        end else begin
            m_lo = a;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        if (op >= 2'd2) begin
            chk("move_hi", 64'(hi), 64'(m_hi));
            chk("move_lo", 64'(lo), 64'(m_lo));
            chk("move_dz", 64'(divZero), 64'(m_dz));
            chk("move_busy", 64'(busy), 64'd0);
            chk("move_done", 64'(done), 64'd0);
        end
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eh, input logic [7:0] el);
        int nb = 0;
        int t  = 0;
        @(negedge clk);
        start8 = 1'b1; oper8 = op; srcA8 = a; srcB8 = b;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        @(negedge clk);
        while (!done8 && t < 50) begin
            if (busy8) nb++;
            @(negedge clk);
            t++;
        end
        chk("w8_done_seen", 64'(done8), 64'd1);
        chk("w8_busy_cycles", 64'(nb), 64'd8);
        chk("w8_hi", 64'(hi8), 64'(eh));
        chk("w8_lo", 64'(lo8), 64'(el));
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                chk("latency", 64'(busy_run), 64'(W));
                busy_run = 0;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("res_hi", 64'(hi), 64'(e.hi));
                    chk("res_lo", 64'(lo), 64'(e.lo));
                    chk("res_dz", 64'(divZero), 64'(e.dz));
                end
            end else if (busy) begin
                busy_run++;
            end else begin
                busy_run = 0;
            end
        end else begin
            busy_run = 0;
        end
    end

    initial begin
        exp_t e;
        int   t;
        rst_n = 1'b0; start = 1'b1; oper = 2'd2; srcA = 32'h55; srcB = '0;
        start8 = 1'b0; oper8 = '0; srcA8 = '0; srcB8 = '0;
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dz", 64'(divZero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;

        issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'd1, 32'd100, 32'd7);
        issue(2'd1, 32'd5, 32'd0);
        issue(2'd0, 32'd3, 32'd4);
        wait_free();
        issue(2'd2, 32'h1234, 32'hDEAD);
        issue(2'd3, 32'hABCD, 32'hBEEF);

        for (int i = 0; i < 24; i++) begin
            logic [W-1:0] a, b;
            a = $urandom;
            b = (i % 5 == 0) ? '0 : ((i % 3 == 0) ? W'($urandom_range(1, 300)) : $urandom);
            issue(2'($urandom_range(0, 3)), a, b);
        end

        // Start held through RUN with junk operands; only the DONE-cycle request may be taken
        wait_free();
        start = 1'b1; oper = 2'd0; srcA = $urandom; srcB = $urandom;
        e = model(2'd0, srcA, srcB);
        sb.push_back(e);
        @(posedge clk);
        t = 0;
        while (t < 100) begin
            @(negedge clk);
            t++;
            if (done) break;
            oper = 2'($urandom_range(0, 3)); srcA = $urandom; srcB = $urandom;
        end
        chk("b2b_done_seen", 64'(done), 64'd1);
        oper = 2'd1; srcA = 32'd100; srcB = 32'd7;
        sb.push_back(model(2'd1, 32'd100, 32'd7));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_free();

        run8(2'd0, 8'd200, 8'd200, 8'h9C, 8'h40);
        run8(2'd1, 8'd255, 8'd16, 8'h0F, 8'h0F);

        // Reset mid-multiply: the aborted op must never report
        issue(2'd0, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_lo", 64'(lo), 64'd0);
        chk("abort_dz", 64'(divZero), 64'd0);
        m_hi = '0; m_lo = '0; m_dz = 1'b0;
        repeat (40) @(posedge clk);
        issue(2'd0, 32'd3, 32'd4);

        t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sm_muldiv.md
SM_MULDIV -- requirements
Module: sm_muldiv

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result word width; legal range 2..64.
REQ-002 Port: clk  input  1  clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset; one clock, synchronous, active-low.
REQ-004 Port: start  input  1  request strobe; sampled on rising edge of clk.
REQ-005 Port: oper  input  2  operation: 0 MULTU, 1 DIVU, 2 MTHI, 3 MTLO.
REQ-006 Port: srcA  input  WIDTH  multiplicand / dividend / move source.
REQ-007 Port: srcB  input  WIDTH  multiplier / divisor; ignored for MTHI/MTLO.
REQ-008 Port: busy  output  1  high while an iterative operation runs.
REQ-009 Port: done  output  1  one-cycle pulse: hi/lo hold a new MULTU/DIVU result.
REQ-010 Port: divZero  output  1  last completed DIVU had srcB == 0.
REQ-011 Port: hi  output  WIDTH  HI register (product upper half / remainder).
REQ-012 Port: lo  output  WIDTH  LO register (product lower half / quotient).

Function
REQ-013 States: IDLE, RUN, DONE; busy = (state == RUN); done = (state == DONE).
REQ-014 Start accepted only on an edge with start=1 and state IDLE or DONE; start during RUN ignored, no side effects.
REQ-015 Accepted MULTU/DIVU: srcA/srcB captured into internal working registers; iteration counter loaded with WIDTH-1; state -> RUN.
REQ-016 RUN: one radix-2 iteration per edge; on the edge where counter == 0, final iteration completes, hi/lo written, state -> DONE; otherwise counter decrements.
REQ-017 Latency: start sampled at edge k -> busy high cycles k+1..k+WIDTH -> done high for exactly the cycle after edge k+WIDTH, with hi/lo valid from that cycle on.
REQ-018 DONE -> IDLE on the next edge unless a new start is accepted there (back-to-back, REQ-014).
REQ-019 MULTU: unsigned shift-add; 2*WIDTH-bit product, {hi, lo} = srcA * srcB.
REQ-020 DIVU: unsigned restoring division; lo = quotient, hi = remainder.
REQ-021 DIVU with srcB == 0: lo = all ones, hi = srcA, divZero = 1 (natural restoring result, no special path required beyond flag).
REQ-022 divZero updated only on the DONE-entry edge of DIVU (set per REQ-021, cleared otherwise) and cleared on the DONE-entry edge of MULTU.
REQ-023 hi/lo unchanged during RUN; only the DONE-entry edge, MTHI/MTLO, or reset modifies them.
REQ-024 Accepted MTHI: hi <= srcA on that edge; MTLO: lo <= srcA; state -> IDLE; busy, done stay 0; divZero unchanged.
REQ-025 Intermediate arithmetic carries one extra bit where needed so no iteration overflows for any WIDTH in range.

Reset
REQ-026 rst_n low at an edge: state IDLE, counter 0, hi = 0, lo = 0, busy = 0, done = 0, divZero = 0, working registers 0.
REQ-027 Reset during RUN or DONE aborts the operation; no done pulse for that operation after reset release.
REQ-028 start with rst_n low is ignored; first acceptable start is at the first edge with rst_n high.

Verification
REQ-029 WIDTH=32, MULTU srcA=0xFFFFFFFF srcB=0xFFFFFFFF at edge k -> done in cycle after edge k+32, hi=0xFFFFFFFE, lo=0x00000001, divZero=0.
REQ-030 WIDTH=32, DIVU 100 / 7 -> lo=14, hi=2, divZero=0; then DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, divZero=1; then MULTU 3*4 -> hi=0, lo=12, divZero=0.
REQ-031 start asserted every cycle of RUN with differing operands -> exactly one done per accepted op, result from first operands; start in DONE cycle accepted, busy high next cycle.
REQ-032 rst_n low for one edge at iteration 10 of a MULTU -> busy=0, hi=lo=0 next cycle, done never pulses for that op.
REQ-033 Idle, MTHI srcA=0x1234 then MTLO srcA=0xABCD -> hi=0x1234, lo=0xABCD after respective edges, busy=0, done=0 throughout.
REQ-034 WIDTH=8, MULTU 200*200 -> done after 8 busy cycles, hi=0x9C, lo=0x40; DIVU 255/16 -> lo=0x0F, hi=0x0F.
